mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter that shares port B of the 16-bit × 32K dual-port block memory between two bus masters (requester 0: CPU-side I/O or DMA; requester 1: display/timer/motor fetch engine). It accepts single-word read/write requests, issues at most one access per cycle on the memory port, and routes the synchronous read data back to the requester that issued it with a `rvalid` pulse. Port A stays dedicated to the CPU and is not touched by this block.

## Interface
- `DATA_W`, 16, memory word width
- `ADDR_W`, 15, memory address width (32768 words)
- `FIXED_PRIO`, 0, 0 = round-robin, 1 = requester 0 always wins ties
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req0` / `req1`  in  1  request valid; held with its command until the matching ack
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  ADDR_W  word address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `ack0` / `ack1`  out  1  one-cycle pulse: command accepted and on the memory port this cycle
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` holds read result for that requester
- `rdata0` / `rdata1`  out  DATA_W  read data, `mem_dout` passed through; qualified only by `rvalid`
- `mem_en`, `mem_we`  out  1  to memory `enB`, `weB`
- `mem_addr`  out  ADDR_W  to `addrB`
- `mem_din`  out  DATA_W  to `dinB`
- `mem_dout`  in  DATA_W  from `doutB`

## Operation
- Eligible(i) = `req_i` and not `ack_i` (a requester is never granted in the cycle its ack is high; this suppresses double issue while the requester drops or updates `req`).
- Arbitration each cycle over eligible requesters: one eligible → grant it; both eligible → `FIXED_PRIO`=1: requester 0; `FIXED_PRIO`=0: the one not granted last (`last` pointer).
- On grant of i, registered at the edge: `mem_en`=1, `mem_we`=`we_i`, `mem_addr`=`addr_i`, `mem_din`=`wdata_i`, `ack_i`=1, `last`=i. No grant: `mem_en`=0, `mem_we`=0, acks 0; `mem_addr`/`mem_din` hold previous values.
- Read tag pipeline: on a read grant, tag stage 1 ← {valid=1, id=i}; stage 2 ← stage 1 next edge; `rvalid_id`=stage2.valid and id match. Writes push valid=0 (no rvalid for writes).
- `rdata0` and `rdata1` both continuously equal `mem_dout`.
- Write-first memory behaviour is inherited: a read issued the cycle after a write to the same address returns the new data; the arbiter does no hazard tracking.
- No state machine beyond the `last` pointer and two-stage tag pipeline; arbitration is per cycle.

## Timing
- Reset (asynchronous, while `rst_n`=0): `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `ack0`=`ack1`=0, `rvalid0`=`rvalid1`=0, tag pipeline cleared, `last`=1 (requester 0 wins first tie). Release synchronous to `clk` by system convention.
- Request sampled at edge E → ack and memory command visible in cycle E..E+1.
- Memory captures at E+1; `rvalid` and `rdata` valid in cycle E+1..E+2. Read latency = 2 cycles from sampling edge.
- Throughput: one access per cycle on the port; a single requester with continuous `req` gets one access every 2 cycles; two continuously requesting alternate and fill every cycle.
- Reset mid-operation: in-flight reads are dropped, no `rvalid` emitted after reset, even for commands already acked.
- Requester changing address/data while `req` high and unacked: latest values at the sampling edge are used.

## Test plan
- Reset: drive both `req`=1, `rst_n`=0 → all outputs 0; release, first tie edge grants requester 0 (`ack0`=1, `mem_addr`=addr0).
- Single read: write 0xBEEF to 0x0123 via req1, then read 0x0123 via req0 → `ack0` one cycle after sampling, `rvalid0`=1 with `rdata0`=0xBEEF exactly 2 cycles after sampling; `rvalid1` stays 0.
- Contention, round-robin: both hold `req` with reads to 0x0010/0x0020 for 8 cycles → `mem_en`=1 every cycle, acks alternate 0,1,0,1…, each `rvalid` returns matching data 2 cycles later with correct id.
- Fixed priority (`FIXED_PRIO`=1): both request continuously → grants 0,1,0,1 (ack-cycle rule forces alternation); req0 held off → req1 granted every other cycle, `mem_en` gaps between.
- Write then read same address back-to-back: req0 write 0x7FFF←0x1234, req1 read 0x7FFF next cycle → `rvalid1` data 0x1234; writes never raise `rvalid`.
- Reset mid-read: assert `rst_n`=0 the cycle after `ack0` on a read → no `rvalid0` ever appears, `mem_en` 0 immediately.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory port B signals for the
// two-requester memory port arbiter.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    // Requester 0 (CPU-side I/O or DMA)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    // Requester 1 (display/timer/motor fetch engine)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    // Memory port B
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // Requester side: drives commands, receives acks and read data
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rvalid0, rdata0,
        input  ack1, rvalid1, rdata1
    );

    // Arbiter side: accepts commands, drives the memory port
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rvalid0, rdata0,
        output ack1, rvalid1, rdata1,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    // Memory side: consumes the port B command, returns read data
    modport mem (
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares port B of the dual-port block memory between two requesters.
// One access per cycle at most; read data comes back two cycles after the
// sampling edge, steered to its issuer by a two-stage tag pipeline.
module mem_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 15,
    parameter int FIXED_PRIO = 0
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.slave bus
);

    logic              ack0_q;
    logic              ack1_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;

    // last = 1 means requester 1 was granted most recently
    logic              last;

    logic              tag1_valid;
    logic              tag1_id;
    logic              tag2_valid;
    logic              tag2_id;

    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;

    // A requester whose ack is high this cycle is not eligible, so a held
    // req cannot be issued twice; ties go to fixed priority or the one not granted last.
    always_comb begin
        elig0  = bus.req0 & ~ack0_q;
        elig1  = bus.req1 & ~ack1_q;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if ((FIXED_PRIO != 0) || last) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    // Register the granted command onto the memory port and track read tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            last       <= 1'b1;
            tag1_valid <= 1'b0;
            tag1_id    <= 1'b0;
            tag2_valid <= 1'b0;
            tag2_id    <= 1'b0;
        end else begin
            ack0_q     <= grant0;
            ack1_q     <= grant1;
            mem_en_q   <= grant0 | grant1;
            tag1_valid <= 1'b0;
            if (grant0) begin
                mem_we_q   <= bus.we0;
                mem_addr_q <= bus.addr0;
                mem_din_q  <= bus.wdata0;
                last       <= 1'b0;
                tag1_valid <= ~bus.we0;
                tag1_id    <= 1'b0;
            end else if (grant1) begin
                mem_we_q   <= bus.we1;
                mem_addr_q <= bus.addr1;
                mem_din_q  <= bus.wdata1;
                last       <= 1'b1;
                tag1_valid <= ~bus.we1;
                tag1_id    <= 1'b1;
            end else begin
                mem_we_q   <= 1'b0;
            end
            tag2_valid <= tag1_valid;
            tag2_id    <= tag1_id;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;

    // The second tag stage lines up with the memory's registered output.
    assign bus.rvalid0  = tag2_valid & ~tag2_id;
    assign bus.rvalid1  = tag2_valid &  tag2_id;
    assign bus.rdata0   = bus.mem_dout;
    assign bus.rdata1   = bus.mem_dout;

endmodule
